flag_cond_unit: RTL and testbench

Flags consumer for the pcpu core, downstream of the ALU's 5-bit flags output. It holds the live architectural flags register, evaluates 4-bit branch/skip condition codes against it with a registered result, and provides a LIFO flag save/restore stack used by the interrupt entry and return sequence.

---
 rtl/pcpu_pkg.sv | 29 ++
 rtl/flag_stack.sv | 58 +++++
 rtl/flag_cond_unit.sv | 115 +++++++++++
 tb/tb_flag_cond_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared pcpu definitions: flag bit positions, branch condition codes and the flags type.
package pcpu_pkg;

    typedef logic [4:0] flags_t;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_O = 3;
    localparam int FLG_P = 4;

    localparam logic [3:0] CC_AL  = 4'd0;
    localparam logic [3:0] CC_Z   = 4'd1;
    localparam logic [3:0] CC_NZ  = 4'd2;
    localparam logic [3:0] CC_C   = 4'd3;
    localparam logic [3:0] CC_NC  = 4'd4;
    localparam logic [3:0] CC_N   = 4'd5;
    localparam logic [3:0] CC_NN  = 4'd6;
    localparam logic [3:0] CC_O   = 4'd7;
    localparam logic [3:0] CC_NO  = 4'd8;
    localparam logic [3:0] CC_P   = 4'd9;
    localparam logic [3:0] CC_NP  = 4'd10;
    localparam logic [3:0] CC_LT  = 4'd11;
    localparam logic [3:0] CC_GE  = 4'd12;
    localparam logic [3:0] CC_LE  = 4'd13;
    localparam logic [3:0] CC_GT  = 4'd14;
    localparam logic [3:0] CC_UGT = 4'd15;

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag words with occupancy count and sticky {underflow, overflow} detection.
module flag_stack
    import pcpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    input  flags_t        push_data,
    output flags_t        top_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [1:0]    err
);

    flags_t        mem [DEPTH];
    logic [CW-1:0] count_m1;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Pop has priority; a push in the same cycle is dropped without raising overflow.
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop && !full;
    assign count_m1 = count - CW'(1);
    assign top_data = mem[count_m1[AW-1:0]];

    // NOTE: entries are not reset; the count is, and no entry is read before it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[count[AW-1:0]] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= '0;
        end else begin
            if (do_pop) begin
                count <= count_m1;
            end else if (do_push) begin
                count <= count + CW'(1);
            end
            // A new error in the clearing cycle still ends set.
            err <= (err & ~{2{err_clr}}) | {pop && empty, push && !pop && full};
        end
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Live flags register, registered condition evaluation and optional flag save/restore stack.
// The stack exists only when FLAG_STACK_EN is defined.
module flag_cond_unit
    import pcpu_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [4:0]                         flags_in,
    input  logic                               flags_we,
    input  logic [3:0]                         cond,
    input  logic                               eval,
    output logic                               taken,
    output logic                               taken_valid,
    output logic [4:0]                         flags_q,
    input  logic                               push,
    input  logic                               pop,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_count,
    output logic [1:0]                         stk_err,
    input  logic                               err_clr
);

    flags_t flags_r;
    logic   cond_true;
    logic   signed_lt;

    assign flags_q   = flags_r;
    assign signed_lt = flags_r[FLG_N] ^ flags_r[FLG_O];

    // NOTE: cond_true gets a default first so no path through the case can infer a latch.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_AL:  cond_true = 1'b1;
            CC_Z:   cond_true = flags_r[FLG_Z];
            CC_NZ:  cond_true = !flags_r[FLG_Z];
            CC_C:   cond_true = flags_r[FLG_C];
            CC_NC:  cond_true = !flags_r[FLG_C];
            CC_N:   cond_true = flags_r[FLG_N];
            CC_NN:  cond_true = !flags_r[FLG_N];
            CC_O:   cond_true = flags_r[FLG_O];
            CC_NO:  cond_true = !flags_r[FLG_O];
            CC_P:   cond_true = flags_r[FLG_P];
            CC_NP:  cond_true = !flags_r[FLG_P];
            CC_LT:  cond_true = signed_lt;
            CC_GE:  cond_true = !signed_lt;
            CC_LE:  cond_true = flags_r[FLG_Z] | signed_lt;
            CC_GT:  cond_true = !flags_r[FLG_Z] & !signed_lt;
            CC_UGT: cond_true = !flags_r[FLG_C] & !flags_r[FLG_Z];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else begin
            taken_valid <= eval;
            if (eval) begin
                taken <= cond_true;
            end
        end
    end

`ifdef FLAG_STACK_EN
    flags_t stk_top;
    logic   stk_empty;
    logic   unused_stk_full;

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_flag_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .push_data (flags_r),
        .top_data  (stk_top),
        .count     (stk_count),
        .full      (unused_stk_full),
        .empty     (stk_empty),
        .err       (stk_err)
    );

    // A pop owns the live register for the cycle, even when the stack is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else if (pop) begin
            if (!stk_empty) begin
                flags_r <= stk_top;
            end
        end else if (flags_we) begin
            flags_r <= flags_in;
        end
    end
`else
    logic unused_stack_ctl;

    assign stk_count        = '0;
    assign stk_err          = '0;
    assign unused_stack_ctl = ^{push, pop, err_clr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else if (flags_we) begin
            flags_r <= flags_in;
        end
    end
`endif

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: behavioural model compared every cycle plus directed literals.
module tb_flag_cond_unit;

    localparam int STACK_DEPTH = 4;
    localparam int CW          = $clog2(STACK_DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [4:0]    flags_in;
    logic          flags_we;
    logic [3:0]    cond;
    logic          eval;
    logic          taken;
    logic          taken_valid;
    logic [4:0]    flags_q;
    logic          push;
    logic          pop;
    logic [CW-1:0] stk_count;
    logic [1:0]    stk_err;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    flag_cond_unit #(
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flags_in    (flags_in),
        .flags_we    (flags_we),
        .cond        (cond),
        .eval        (eval),
        .taken       (taken),
        .taken_valid (taken_valid),
        .flags_q     (flags_q),
        .push        (push),
        .pop         (pop),
        .stk_count   (stk_count),
        .stk_err     (stk_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Condition truth straight from the flag meanings.
    function automatic bit cond_model(input int c, input logic [4:0] f);
        bit z  = f[0];
        bit cy = f[1];
        bit n  = f[2];
        bit o  = f[3];
        bit p  = f[4];
        bit lt = (n != o);
        case (c)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return cy;
            4:  return !cy;
            5:  return n;
            6:  return !n;
            7:  return o;
            8:  return !o;
            9:  return p;
            10: return !p;
            11: return lt;
            12: return !lt;
            13: return z || lt;
            14: return !z && !lt;
            15: return !cy && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model state.
    logic [4:0] m_flags;
    logic       m_taken;
    logic       m_valid;
    int         m_cnt;
    logic [1:0] m_err;
    logic [4:0] m_stk [STACK_DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= '0;
            m_taken <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_err   <= '0;
        end else begin
            m_valid <= eval;
            if (eval) m_taken <= cond_model(int'(cond), m_flags);
`ifdef FLAG_STACK_EN
            m_err[1] <= (m_err[1] && !err_clr) || (pop && m_cnt == 0);
            m_err[0] <= (m_err[0] && !err_clr) || (push && !pop && m_cnt == STACK_DEPTH);
            if (pop) begin
                if (m_cnt > 0) begin
                    m_flags <= m_stk[m_cnt-1];
                    m_cnt   <= m_cnt - 1;
                end
            end else begin
                if (push && m_cnt < STACK_DEPTH) begin
                    m_stk[m_cnt] <= m_flags;
                    m_cnt        <= m_cnt + 1;
                end
                if (flags_we) m_flags <= flags_in;
            end
`else
            if (flags_we) m_flags <= flags_in;
`endif
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_taken_valid", 32'(taken_valid), 32'(m_valid));
            check("cmp_taken", 32'(taken), 32'(m_taken));
            check("cmp_flags_q", 32'(flags_q), 32'(m_flags));
            check("cmp_stk_count", 32'(stk_count), 32'(m_cnt));
            check("cmp_stk_err", 32'(stk_err), 32'(m_err));
        end
    end

    initial begin
        logic [4:0] pats [4];
        int         conds [4];
        logic       exp_seq [4];

        rst_n = 1'b0; flags_in = '0; flags_we = 1'b0; cond = '0; eval = 1'b0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #12;
        check("rst_flags_q", 32'(flags_q), 32'h0);
        check("rst_taken", 32'(taken), 32'h0);
        check("rst_taken_valid", 32'(taken_valid), 32'h0);
        check("rst_stk_count", 32'(stk_count), 32'h0);
        check("rst_stk_err", 32'(stk_err), 32'h0);
        rst_n = 1'b1;
        check_en = 1'b1;
        cycle();

        // Always-true condition right after reset.
        eval = 1'b1; cond = 4'd0;
        cycle();
        eval = 1'b0;
        check("al_taken", 32'(taken), 32'h1);
        check("al_valid", 32'(taken_valid), 32'h1);
        check("al_flags", 32'(flags_q), 32'h0);

        // O and Z set: Z, LT, LE, GT back to back.
        flags_in = 5'b01001; flags_we = 1'b1;
        cycle();
        flags_we = 1'b0;
        conds   = '{1, 11, 13, 14};
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            eval = 1'b1; cond = 4'(conds[i]);
            cycle();
            check("seq_taken", 32'(taken), 32'(exp_seq[i]));
            check("seq_valid", 32'(taken_valid), 32'h1);
        end
        eval = 1'b0;
        cycle();
        check("hold_valid", 32'(taken_valid), 32'h0);
        check("hold_taken", 32'(taken), 32'h0);

        // Same-cycle load is invisible to the evaluation.
        flags_in = 5'b00100; flags_we = 1'b1; eval = 1'b1; cond = 4'd5;
        cycle();
        flags_we = 1'b0;
        check("old_flags_taken", 32'(taken), 32'h0);
        cycle();
        eval = 1'b0;
        check("new_flags_taken", 32'(taken), 32'h1);

        // Sweep every condition code over several flag patterns.
        pats = '{5'b00000, 5'b00010, 5'b10110, 5'b01100};
        for (int p = 0; p < 4; p++) begin
            flags_in = pats[p]; flags_we = 1'b1;
            cycle();
            flags_we = 1'b0;
            for (int c = 0; c < 16; c++) begin
                eval = 1'b1; cond = 4'(c);
                cycle();
            end
            eval = 1'b0;
        end
        cycle();

`ifdef FLAG_STACK_EN
        for (int v = 1; v <= 4; v++) begin
            flags_in = 5'(v); flags_we = 1'b1;
            cycle();
            flags_we = 1'b0; push = 1'b1;
            cycle();
            push = 1'b0;
            check("push_count", 32'(stk_count), 32'(v));
        end
        push = 1'b1;
        cycle();
        push = 1'b0;
        check("ovf_err", 32'(stk_err), 32'h1);
        check("ovf_count", 32'(stk_count), 32'h4);
        check("ovf_flags", 32'(flags_q), 32'h4);

        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("pop_flags", 32'(flags_q), 32'(4 - k));
        end
        cycle();
        pop = 1'b0;
        check("udf_err", 32'(stk_err), 32'h3);
        check("udf_flags", 32'(flags_q), 32'h1);
        check("udf_count", 32'(stk_count), 32'h0);

        err_clr = 1'b1; pop = 1'b1;
        cycle();
        pop = 1'b0;
        check("clr_with_new_err", 32'(stk_err), 32'h2);
        cycle();
        err_clr = 1'b0;
        check("clr_err", 32'(stk_err), 32'h0);

        // Push with load, then pop with load.
        flags_in = 5'h02; flags_we = 1'b1;
        cycle();
        flags_in = 5'h07; push = 1'b1;
        cycle();
        push = 1'b0;
        check("push_we_flags", 32'(flags_q), 32'h07);
        check("push_we_count", 32'(stk_count), 32'h1);
        flags_in = 5'h1F; pop = 1'b1;
        cycle();
        pop = 1'b0; flags_we = 1'b0;
        check("pop_we_flags", 32'(flags_q), 32'h02);
        check("pop_we_count", 32'(stk_count), 32'h0);

        // Push and pop together on an empty stack: pop wins, underflow only.
        push = 1'b1; pop = 1'b1;
        cycle();
        push = 1'b0; pop = 1'b0;
        check("pushpop_err", 32'(stk_err), 32'h2);
        check("pushpop_count", 32'(stk_count), 32'h0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        push = 1'b1;
        cycle(); cycle(); cycle();
        push = 1'b0;
        check("prep_count", 32'(stk_count), 32'h3);
`else
        flags_in = 5'h12; flags_we = 1'b1; push = 1'b1; pop = 1'b1; err_clr = 1'b1;
        cycle();
        flags_we = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        check("nostk_flags", 32'(flags_q), 32'h12);
        check("nostk_count", 32'(stk_count), 32'h0);
        check("nostk_err", 32'(stk_err), 32'h0);
        push = 1'b1;
        cycle();
        push = 1'b0;
        check("nostk_push_count", 32'(stk_count), 32'h0);
`endif

        // Asynchronous reset with an evaluation pending.
        eval = 1'b1; cond = 4'd0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_flags", 32'(flags_q), 32'h0);
        check("arst_taken", 32'(taken), 32'h0);
        check("arst_valid", 32'(taken_valid), 32'h0);
        check("arst_count", 32'(stk_count), 32'h0);
        check("arst_err", 32'(stk_err), 32'h0);
        eval = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle();
        check("post_rst_valid", 32'(taken_valid), 32'h0);
        check("post_rst_count", 32'(stk_count), 32'h0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
